mpmc9_burst_sched: RTL
======================

# mpmc9_burst_sched

Round-robin channel scheduler and burst sequencer for the mpmc9 eight-port memory controller. It picks one of eight requesting channels, fixes the burst length (strip count) for that channel, issues one memory-interface command per strip with an incrementing address, counts returned read data, and pulses a per-channel done. It sits between the channel request/address muxes and the DDR application interface (app_*).

## Interface
- S0..S7, default 63,1,31,63,0,63,63,3: read burst length minus one (strips) for channels 0..7; 6 bits each.
- STRIP_BYTES, default 16: address increment per strip; must be a power of two.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- req  in  8  per-channel request, level; bit n = channel n.
- we  in  8  per-channel write flag, valid while req[n] is high.
- adr_i  in  32  byte address of channel `ch`, muxed externally from `ch`.
- app_rdy  in  1  memory interface accepts a command this cycle.
- app_wdf_rdy  in  1  write-data FIFO accepts a beat this cycle.
- app_rd_data_valid  in  1  one read strip returned this cycle.
- ch  out  4  granted channel; reset 0.
- num_strips  out  6  strips minus one for the current burst; reset 0.
- app_en  out  1  command valid; reset 0.
- app_cmd  out  3  3'd1 read, 3'd0 write; reset 0.
- app_addr  out  32  strip address; reset 0.
- app_wdf_wren, app_wdf_end  out  1  write beat valid / last beat; reset 0.
- done  out  8  one-cycle completion pulse per channel; reset 0.
- busy  out  1  high in any state other than IDLE; reset 0.

## Operation
- States: IDLE, GRANT, CMD, WAIT_RD, ACK. Reset forces IDLE, clears all outputs, sets last_ch = 7.
- IDLE: if any req bit is set, choose the first set bit searching last_ch+1, last_ch+2, ... (mod 8). Register ch and last_ch. Go to GRANT. If req = 0, stay in IDLE.
- GRANT, one cycle: sample adr_i and we[ch].
  - Read: num_strips = S[ch].
  - Write: num_strips = 0.
  - app_addr = adr_i with log2(STRIP_BYTES) low bits cleared.
  - Clear cmd_cnt and rd_cnt. Go to CMD.
- CMD: app_en = 1. app_cmd = write ? 0 : 1.
  - Write: app_wdf_wren = app_wdf_end = app_en. A command is accepted when app_rdy & app_wdf_rdy.
  - Read: a command is accepted when app_rdy.
  - On each accept: cmd_cnt += 1 and app_addr += STRIP_BYTES (32-bit wrap).
  - On the accept where cmd_cnt == num_strips: drop app_en, app_wdf_*. Write goes to ACK; read goes to WAIT_RD.
- rd_cnt increments on app_rd_data_valid in both CMD and WAIT_RD, because data can return before all commands have issued.
- WAIT_RD: when rd_cnt == num_strips and app_rd_data_valid is high (the final strip), go to ACK. If the final strip already arrived during CMD, go directly from CMD to ACK.
- ACK, one cycle: done[ch] = 1, then IDLE.
- Boundaries:
  - req[ch] dropping mid-burst is ignored; the burst completes.
  - app_rd_data_valid in IDLE, GRANT or ACK is ignored.
  - S = 0 gives a single-strip burst.
  - Max burst is 64 strips; counters are 6 bits plus a terminal compare, with no overflow.

## Timing
- req seen in IDLE at cycle t: ch is valid at t+1 (GRANT). app_en first high at t+2.
- app_en/app_addr/app_cmd are held stable until accepted. The next strip address appears the cycle after an accept.
- Write, app_rdy & app_wdf_rdy always high: req at t, done at t+3. Earliest new grant at t+4.
- Read of N+1 strips with no stalls: last command at t+2+N. done one cycle after the last rd_data_valid is counted.
- done and busy are registered. busy falls the cycle after ACK.

## Test plan
- Reset mid-CMD (read ch0, 10 strips issued) -> next cycle app_en=0, busy=0, done=0, ch=0; the following req[1] is granted first after reset (last_ch=7, so channel 0 wins if also requesting).
- req=8'hFF held, all reads, app_rdy=1, data returned 5 cycles after each command -> grant order 0,1,2,...,7,0. Per-channel done pulses in that order. Command counts 64,2,32,64,1,64,64,4.
- ch2 read, adr_i=32'h0000_1008, app_rdy=1 -> app_addr sequence 0x1000, 0x1010, ... 0x11F0 (32 strips). done[2] after the 32nd rd_data_valid.
- ch5 write, app_wdf_rdy low for 3 cycles with app_rdy=1 -> app_en held, address unchanged, exactly one accept. done[5] 1 cycle after the accept.
- ch7 read with all 4 rd_data_valid returned during CMD (app_rdy toggling 1,0,1,0...) -> CMD goes straight to ACK, skipping WAIT_RD. done[7] single pulse.
- adr_i=32'hFFFF_FFF0, ch1 read (2 strips) -> app_addr 0xFFFF_FFF0 then 0x0000_0000.

Source files
------------

// File: rtl/mpmc9_burst_sched_if.sv
// Request/command bundle between the mpmc9 channel muxes, the burst scheduler
// and the DDR application interface.
interface mpmc9_burst_sched_if;
  logic [7:0]  req;
  logic [7:0]  we;
  logic [31:0] adr_i;
  logic        app_rdy;
  logic        app_wdf_rdy;
  logic        app_rd_data_valid;
  logic [3:0]  ch;
  logic [5:0]  num_strips;
  logic        app_en;
  logic [2:0]  app_cmd;
  logic [31:0] app_addr;
  logic        app_wdf_wren;
  logic        app_wdf_end;
  logic [7:0]  done;
  logic        busy;

  modport master (
    input  req, we, adr_i, app_rdy, app_wdf_rdy, app_rd_data_valid,
    output ch, num_strips, app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
           done, busy
  );

  modport slave (
    output req, we, adr_i, app_rdy, app_wdf_rdy, app_rd_data_valid,
    input  ch, num_strips, app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
           done, busy
  );
endinterface

// File: rtl/mpmc9_burst_sched.sv
// mpmc9 round-robin channel scheduler: grants one of eight channels, issues one
// app command per strip and pulses done[ch] once the burst has fully completed.
//
// state   | meaning
// IDLE    | waiting for any req, round-robin pick after last_ch
// GRANT   | latch address, direction and strip count of ch
// CMD     | app_en held until each strip command is accepted
// WAIT_RD | all read commands issued, waiting for the final strip
// ACK     | one-cycle done[ch] pulse
module mpmc9_burst_sched #(
  parameter logic [5:0] S0 = 6'd63, S1 = 6'd1,  S2 = 6'd31, S3 = 6'd63,
  parameter logic [5:0] S4 = 6'd0,  S5 = 6'd63, S6 = 6'd63, S7 = 6'd3,
  parameter int         STRIP_BYTES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mpmc9_burst_sched_if.master  bus
);

  typedef enum logic [2:0] {IDLE, GRANT, CMD, WAIT_RD, ACK} state_t;

  localparam logic [31:0] STRIP_INC = 32'(STRIP_BYTES);
  localparam logic [31:0] ADDR_MASK = ~(STRIP_INC - 32'd1);

  state_t      state_q, state_d;
  logic [2:0]  ch_q, ch_d;
  logic [2:0]  last_ch_q, last_ch_d;
  logic [5:0]  num_strips_q, num_strips_d;
  logic        wr_q, wr_d;
  logic        app_en_q, app_en_d;
  logic [2:0]  app_cmd_q, app_cmd_d;
  logic [31:0] app_addr_q, app_addr_d;
  logic        wdf_q, wdf_d;
  logic [7:0]  done_q, done_d;
  logic        busy_q, busy_d;
  logic [5:0]  cmd_cnt_q, cmd_cnt_d;
  logic [5:0]  rd_cnt_q, rd_cnt_d;
  logic        rd_done_q, rd_done_d;

  logic [2:0]  pick, rr_idx;
  logic        found;
  logic [5:0]  s_cur;
  logic        accept, cmd_final, rd_live, rd_final;

  always_comb begin
    pick   = last_ch_q;
    found  = 1'b0;
    rr_idx = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      rr_idx = last_ch_q + 3'(i);
      if (!found && bus.req[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  always_comb begin
    case (ch_q)
      3'd0:    s_cur = S0;
      3'd1:    s_cur = S1;
      3'd2:    s_cur = S2;
      3'd3:    s_cur = S3;
      3'd4:    s_cur = S4;
      3'd5:    s_cur = S5;
      3'd6:    s_cur = S6;
      default: s_cur = S7;
    endcase
  end

  // Read data may return while commands are still issuing; a latched final
  // strip (rd_done_q) lets CMD skip WAIT_RD.
  assign accept    = app_en_q & bus.app_rdy & (~wr_q | bus.app_wdf_rdy);
  assign cmd_final = accept & (cmd_cnt_q == num_strips_q);
  assign rd_live   = bus.app_rd_data_valid & ~wr_q & ~rd_done_q &
                     ((state_q == CMD) | (state_q == WAIT_RD));
  assign rd_final  = rd_live & (rd_cnt_q == num_strips_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ch_q         <= 3'd0;
      last_ch_q    <= 3'd7;
      num_strips_q <= 6'd0;
      wr_q         <= 1'b0;
      app_en_q     <= 1'b0;
      app_cmd_q    <= 3'd0;
      app_addr_q   <= 32'd0;
      wdf_q        <= 1'b0;
      done_q       <= 8'd0;
      busy_q       <= 1'b0;
      cmd_cnt_q    <= 6'd0;
      rd_cnt_q     <= 6'd0;
      rd_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      last_ch_q    <= last_ch_d;
      num_strips_q <= num_strips_d;
      wr_q         <= wr_d;
      app_en_q     <= app_en_d;
      app_cmd_q    <= app_cmd_d;
      app_addr_q   <= app_addr_d;
      wdf_q        <= wdf_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      cmd_cnt_q    <= cmd_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_done_q    <= rd_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req) state_d = GRANT;
      GRANT:   state_d = CMD;
      CMD:     if (cmd_final) state_d = (wr_q | rd_done_q | rd_final) ? ACK : WAIT_RD;
      WAIT_RD: if (rd_final) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_d         = ch_q;
    last_ch_d    = last_ch_q;
    num_strips_d = num_strips_q;
    wr_d         = wr_q;
    app_cmd_d    = app_cmd_q;
    app_addr_d   = app_addr_q;
    cmd_cnt_d    = cmd_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    rd_done_d    = rd_done_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          ch_d      = pick;
          last_ch_d = pick;
        end
      end
      GRANT: begin
        wr_d         = bus.we[ch_q];
        num_strips_d = bus.we[ch_q] ? 6'd0 : s_cur;
        app_cmd_d    = bus.we[ch_q] ? 3'd0 : 3'd1;
        app_addr_d   = bus.adr_i & ADDR_MASK;
        cmd_cnt_d    = 6'd0;
        rd_cnt_d     = 6'd0;
        rd_done_d    = 1'b0;
      end
      CMD, WAIT_RD: begin
        if (accept) begin
          cmd_cnt_d  = cmd_cnt_q + 6'd1;
          app_addr_d = app_addr_q + STRIP_INC;
        end
        if (rd_live) rd_cnt_d = rd_cnt_q + 6'd1;
        if (rd_final) rd_done_d = 1'b1;
      end
      default: ;
    endcase
    app_en_d = (state_d == CMD);
    wdf_d    = (state_d == CMD) & wr_d;
    done_d   = (state_d == ACK) ? (8'd1 << ch_q) : 8'd0;
    busy_d   = (state_d != IDLE);
  end

  assign bus.ch           = {1'b0, ch_q};
  assign bus.num_strips   = num_strips_q;
  assign bus.app_en       = app_en_q;
  assign bus.app_cmd      = app_cmd_q;
  assign bus.app_addr     = app_addr_q;
  assign bus.app_wdf_wren = wdf_q;
  assign bus.app_wdf_end  = wdf_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;

endmodule
